// File: rtl/wash_cycle_ctrl.sv
// Washer/dryer program sequencer: start/pause handling, credit check and charge,
// per-minute phase countdown and registered actuator enables.
module wash_cycle_ctrl #(
  parameter int FILL_MIN   = 2,
  parameter int WASH_Q_MIN = 4,
  parameter int WASH_N_MIN = 7,
  parameter int WASH_H_MIN = 11,
  parameter int DRAIN_MIN  = 1,
  parameter int RINSE_MIN  = 3,
  parameter int SPIN_MIN   = 2,
  parameter int DRY_MIN    = 9
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       MIN_TICK,
  input  logic       BTNC,
  input  logic       DOOR,
  input  logic [1:0] MODE,
  input  logic [3:0] CREDIT,
  output logic [2:0] STATE,
  output logic       PAUSED,
  output logic [3:0] PHASE_MIN,
  output logic [6:0] TOTAL_MIN,
  output logic       VALVE,
  output logic       MOTOR,
  output logic       DRAIN,
  output logic       HEATER,
  output logic       LOCK,
  output logic       CHARGE,
  output logic [3:0] CHARGE_AMT,
  output logic       NOFUNDS,
  output logic       DONE
);

  // S_ACCEPT is the charge cycle between the button edge and the first phase; it reads as IDLE.
  typedef enum logic [3:0] {
    S_IDLE, S_ACCEPT, S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_DRY, S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic       paused_reg, paused_next;
  logic [3:0] phase_reg, phase_next;
  logic [6:0] total_reg, total_next;
  logic [1:0] mode_reg, mode_next;
  logic       charge_next, nofunds_next;
  logic [3:0] amt_next;
  logic       btn_q, door_q;
  logic       btn_rise, door_fall, running;

  function automatic logic [3:0] cost_of(input logic [1:0] m);
    case (m)
      2'b00:   cost_of = 4'd1;
      2'b01:   cost_of = 4'd2;
      2'b10:   cost_of = 4'd3;
      default: cost_of = 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] wash_len(input logic [1:0] m);
    case (m)
      2'b00:   wash_len = 4'(WASH_Q_MIN);
      2'b01:   wash_len = 4'(WASH_N_MIN);
      default: wash_len = 4'(WASH_H_MIN);
    endcase
  endfunction

  function automatic logic [6:0] total_of(input logic [1:0] m);
    if (m == 2'b11) total_of = 7'(DRY_MIN);
    else total_of = 7'(FILL_MIN + DRAIN_MIN + RINSE_MIN + SPIN_MIN) + 7'(wash_len(m));
  endfunction

  function automatic logic [3:0] phase_len(input state_t s, input logic [1:0] m);
    case (s)
      S_FILL:  phase_len = 4'(FILL_MIN);
      S_WASH:  phase_len = wash_len(m);
      S_DRAIN: phase_len = 4'(DRAIN_MIN);
      S_RINSE: phase_len = 4'(RINSE_MIN);
      S_SPIN:  phase_len = 4'(SPIN_MIN);
      S_DRY:   phase_len = 4'(DRY_MIN);
      default: phase_len = 4'd0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_FILL:  next_phase = S_WASH;
      S_WASH:  next_phase = S_DRAIN;
      S_DRAIN: next_phase = S_RINSE;
      S_RINSE: next_phase = S_SPIN;
      default: next_phase = S_DONE;
    endcase
  endfunction

  function automatic logic [2:0] state_code(input state_t s);
    case (s)
      S_FILL:  state_code = 3'd1;
      S_WASH:  state_code = 3'd2;
      S_DRAIN: state_code = 3'd3;
      S_RINSE: state_code = 3'd4;
      S_SPIN:  state_code = 3'd5;
      S_DRY:   state_code = 3'd6;
      S_DONE:  state_code = 3'd7;
      default: state_code = 3'd0;
    endcase
  endfunction

  assign btn_rise  = BTNC & ~btn_q;
  assign door_fall = door_q & ~DOOR;
  assign running   = state_reg inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_DRY};

  always_comb begin
    state_next   = state_reg;
    paused_next  = paused_reg;
    phase_next   = phase_reg;
    total_next   = total_reg;
    mode_next    = mode_reg;
    charge_next  = 1'b0;
    amt_next     = 4'd0;
    nofunds_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (btn_rise && DOOR) begin
          if (CREDIT >= cost_of(MODE)) begin
            charge_next = 1'b1;
            amt_next    = cost_of(MODE);
            mode_next   = MODE;
            state_next  = S_ACCEPT;
          end else begin
            nofunds_next = 1'b1;
          end
        end
      end
      S_ACCEPT: begin
        state_next  = (mode_reg == 2'b11) ? S_DRY : S_FILL;
        phase_next  = (mode_reg == 2'b11) ? phase_len(S_DRY, mode_reg) : phase_len(S_FILL, mode_reg);
        total_next  = total_of(mode_reg);
        paused_next = 1'b0;
      end
      S_DONE: begin
        phase_next  = 4'd0;
        total_next  = 7'd0;
        paused_next = 1'b0;
        if (btn_rise || door_fall) state_next = S_IDLE;
      end
      default: begin
        // A button edge always wins over the tick; an open door pauses and swallows the tick.
        if (running) begin
          if (btn_rise) begin
            paused_next = paused_reg ? ~DOOR : 1'b1;
          end else if (!DOOR) begin
            paused_next = 1'b1;
          end else if (MIN_TICK && !paused_reg) begin
            total_next = (total_reg != 7'd0) ? total_reg - 7'd1 : 7'd0;
            if (phase_reg <= 4'd1) begin
              state_next = next_phase(state_reg);
              phase_next = phase_len(next_phase(state_reg), mode_reg);
            end else begin
              phase_next = phase_reg - 4'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_reg  <= S_IDLE;
      paused_reg <= 1'b0;
      phase_reg  <= 4'd0;
      total_reg  <= 7'd0;
      mode_reg   <= 2'b00;
      btn_q      <= 1'b0;
      door_q     <= 1'b0;
      STATE      <= 3'd0;
      VALVE      <= 1'b0;
      MOTOR      <= 1'b0;
      DRAIN      <= 1'b0;
      HEATER     <= 1'b0;
      LOCK       <= 1'b0;
      CHARGE     <= 1'b0;
      CHARGE_AMT <= 4'd0;
      NOFUNDS    <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      paused_reg <= paused_next;
      phase_reg  <= phase_next;
      total_reg  <= total_next;
      mode_reg   <= mode_next;
      btn_q      <= BTNC;
      door_q     <= DOOR;
      STATE      <= state_code(state_next);
      VALVE      <= ~paused_next & (state_next inside {S_FILL, S_RINSE});
      MOTOR      <= ~paused_next & (state_next inside {S_WASH, S_RINSE, S_SPIN, S_DRY});
      DRAIN      <= ~paused_next & (state_next inside {S_DRAIN, S_SPIN});
      HEATER     <= ~paused_next & (state_next == S_DRY);
      LOCK       <= state_next inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_DRY};
      CHARGE     <= charge_next;
      CHARGE_AMT <= amt_next;
      NOFUNDS    <= nofunds_next;
      DONE       <= (state_next == S_DONE);
    end
  end

  assign PAUSED    = paused_reg;
  assign PHASE_MIN = phase_reg;
  assign TOTAL_MIN = total_reg;

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
Program sequencer for the coin-operated washer/dryer. Accepts the start/pause button, door switch, program select and available dollar credit, then steps through the wash or dry phases on one-minute ticks from the slow-clock block. Drives actuator enables, phase and total minutes remaining, and a one-shot charge request to the dollar counter.

Parameters:
FILL_MIN, 2, fill phase length in minutes (legal 1-15, all durations)
WASH_Q_MIN, 4, wash length, quick program
WASH_N_MIN, 7, wash length, normal program
WASH_H_MIN, 11, wash length, heavy program
DRAIN_MIN, 1, drain phase length
RINSE_MIN, 3, rinse phase length
SPIN_MIN, 2, spin phase length
DRY_MIN, 9, dry phase length

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  synchronous reset, active-low
MIN_TICK  in  1  one-cycle pulse per elapsed minute
BTNC  in  1  debounced start/pause level; block edge-detects rising edges internally
DOOR  in  1  1 = door closed
MODE  in  2  00 quick, 01 normal, 10 heavy, 11 dry-only
CREDIT  in  4  dollars available, binary 0-9
STATE  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 6 DRY, 7 DONE
PAUSED  out  1  run suspended
PHASE_MIN  out  4  minutes left in current phase
TOTAL_MIN  out  7  minutes left in program
VALVE, MOTOR, DRAIN, HEATER, LOCK  out  1 each  actuator enables
CHARGE  out  1  one-cycle pulse: deduct CHARGE_AMT dollars
CHARGE_AMT  out  4  cost of accepted program
NOFUNDS  out  1  one-cycle pulse on rejected start
DONE  out  1  high in DONE state

Behaviour:
- Reset (CPU_RESETN=0 at clock edge): STATE=IDLE, PAUSED=0, PHASE_MIN=0, TOTAL_MIN=0, all actuators/CHARGE/CHARGE_AMT/NOFUNDS/DONE=0. Applies mid-run; no refund.
- All outputs registered; actuator/flag outputs reflect the state present after each clock edge.
- Cost: quick 1, normal 2, heavy 3, dry 2.
- IDLE: on rising BTNC with DOOR=1:
  - CREDIT >= cost(MODE): CHARGE=1 and CHARGE_AMT=cost for exactly one cycle; MODE latched; next edge enters FILL (wash programs) or DRY (dry-only), with PHASE_MIN=that phase length and TOTAL_MIN=program sum.
  - Otherwise: NOFUNDS=1 for one cycle; stay IDLE.
  - Rising BTNC with DOOR=0: ignored.
- Wash sequence: FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE. Dry sequence: DRY -> DONE.
- Countdown: MIN_TICK while running and not paused decrements PHASE_MIN and TOTAL_MIN by 1. When PHASE_MIN=1 and a tick occurs, advance to the next phase and load its length in the same cycle. TOTAL_MIN reaches 0 exactly on entry to DONE.
- Pause:
  - Rising BTNC while running (states 1-6) toggles PAUSED.
  - DOOR=0 while running forces PAUSED=1. Resume requires a BTNC edge with DOOR=1; an edge with DOOR=0 leaves PAUSED=1.
  - Ticks while paused are discarded, not queued.
- Simultaneous events: BTNC edge and MIN_TICK in the same running cycle -> pause toggles, tick discarded. A tick in the start-accept cycle is ignored. MODE changes after acceptance are ignored.
- Enables (all 0 when PAUSED except LOCK):
  - VALVE: FILL, RINSE
  - MOTOR: WASH, RINSE, SPIN, DRY
  - DRAIN: DRAIN, SPIN
  - HEATER: DRY
  - LOCK: states 1-6, including paused
- DONE: DONE=1, LOCK=0, PHASE_MIN=0. Returns to IDLE on rising BTNC or on a DOOR 1->0 transition.
- Width rules: TOTAL_MIN max 75 fits 7 bits. Counters never underflow; ticks in IDLE or DONE have no effect.

Test Plan:
- Reset, MODE=01, CREDIT=5, DOOR=1, BTNC pulse -> one CHARGE pulse with CHARGE_AMT=2; next cycle STATE=1, PHASE_MIN=2, TOTAL_MIN=15, VALVE=1, LOCK=1.
- Quick program, 12 ticks -> STATE sequence 1,2,3,4,5,7 at ticks 2,6,7,10,12; TOTAL_MIN=0, DONE=1, LOCK=0.
- MODE=10, CREDIT=2, BTNC -> NOFUNDS pulse, no CHARGE, STATE stays 0. Repeat with DOOR=0 -> no pulses.
- During WASH: BTNC edge coincident with MIN_TICK -> PAUSED=1, PHASE_MIN unchanged, MOTOR=0, LOCK=1; 3 ticks ignored; BTNC -> resume, countdown continues.
- During RINSE: DOOR=0 -> PAUSED=1. BTNC with DOOR=0 -> still paused. DOOR=1 then BTNC -> resumes.
- Dry-only, CREDIT=2: after 4 ticks assert CPU_RESETN=0 -> all outputs at reset values next edge. Then run dry fully -> HEATER=1 for 9 ticks, DONE; DOOR 1->0 -> IDLE.
